// File: rtl/pri_decoder_pkg.sv
// Shared definitions for the priority encoder/decoder pair: index width,
// derived one-hot width and the {enable, index} entry layout.
package pri_decoder_pkg;

    localparam int unsigned PRI_IN_WIDTH  = 4;
    localparam int unsigned PRI_OUT_WIDTH = 2 ** PRI_IN_WIDTH;

    typedef struct packed {
        logic                    enable;
        logic [PRI_IN_WIDTH-1:0] index;
    } pri_entry_t;

    // Reference decode of one entry at the default width.
    function automatic logic [PRI_OUT_WIDTH-1:0] pri_onehot(input pri_entry_t e);
        logic [PRI_OUT_WIDTH-1:0] word;
        word = '0;
        if (e.enable) begin
            word[e.index] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/pri_decoder_skid.sv
// Two-entry valid/ready buffer with head pointer and occupancy count.
// in_ready depends only on registered state and reset, never on out_ready.
module pri_decoder_skid #(
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              head_q;
    logic              head_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              push;
    logic              pop;
    logic              tail;

    always_comb begin
        in_ready  = (count_q != 2'd2) && !reset;
        out_valid = (count_q != 2'd0);
        out_data  = out_valid ? mem_q[head_q] : '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // Write slot is head + count modulo 2; count 2 never pushes.
        tail      = head_q ^ count_q[0];
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail] = in_data;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (reset) begin
            head_d  = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        head_q  <= head_d;
        count_q <= count_d;
    end

endmodule

// File: rtl/pri_decoder_stream.sv
// Streaming 4-to-16 decoder: buffers {enable, index} in a 2-entry skid
// buffer and decodes the head entry to a one-hot word on the output side.
module pri_decoder_stream
    import pri_decoder_pkg::*;
#(
    parameter int unsigned IN_WIDTH = PRI_IN_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      binary_in,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2**IN_WIDTH-1:0]   decoder_out
);

    localparam int unsigned OUT_WIDTH = 2 ** IN_WIDTH;

    logic [IN_WIDTH:0] in_entry;
    logic [IN_WIDTH:0] head_entry;

    assign in_entry = {enable, binary_in};

    pri_decoder_skid #(
        .DATA_W(IN_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head_entry)
    );

    always_comb begin
        decoder_out = '0;
        if (out_valid && head_entry[IN_WIDTH]) begin
            decoder_out[head_entry[IN_WIDTH-1:0]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_pri_decoder_stream.sv
// Bench for pri_decoder_stream: queue model checked every cycle plus
// directed scenarios with literal expected words.
module tb_pri_decoder_stream;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  binary_in;
    logic        enable;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] decoder_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q[$];
    logic [15:0] obs_log[$];

    pri_decoder_stream #(
        .IN_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .binary_in  (binary_in),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .decoder_out(decoder_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of decoded words, depth 2, cleared by reset.
    always @(posedge clk) begin
        bit m_push;
        bit m_pop;
        if (reset) begin
            model_q.delete();
        end else begin
            m_pop  = (model_q.size() != 0) && out_ready;
            m_push = in_valid && (model_q.size() < 2);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(enable ? (16'h1 << binary_in) : 16'h0);
        end
    end

    // Per-cycle compare and handshake log, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] exp_word;
        exp_word = (model_q.size() != 0) ? model_q[0] : 16'h0;
        check("in_ready", {31'b0, in_ready}, {31'b0, (!reset && model_q.size() < 2)});
        check("out_valid", {31'b0, out_valid}, {31'b0, (model_q.size() != 0)});
        check("decoder_out", {16'b0, decoder_out}, {16'b0, exp_word});
        if (out_valid && out_ready) obs_log.push_back(decoder_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] b, input logic e);
        in_valid  = v;
        binary_in = b;
        enable    = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 4'd0, 1'b0);
        step();
        step();
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out", {16'b0, decoder_out}, 32'h0);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic decode of index 5
        set_in(1'b1, 4'd5, 1'b1);
        step();
        set_in(1'b0, 4'd0, 1'b0);
        check("basic_valid", {31'b0, out_valid}, 32'd1);
        check("basic_word", {16'b0, decoder_out}, 32'h0020);
        step();
        check("basic_drain", {31'b0, out_valid}, 32'd0);

        // enable = 0 still transfers, with an all-zero word
        set_in(1'b1, 4'd9, 1'b0);
        step();
        set_in(1'b0, 4'd0, 1'b0);
        check("en0_valid", {31'b0, out_valid}, 32'd1);
        check("en0_word", {16'b0, decoder_out}, 32'h0000);
        step();

        // Full sweep back-to-back
        obs_log.delete();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 4'(i), 1'b1);
            step();
            check("sweep_in_ready", {31'b0, in_ready}, 32'd1);
        end
        set_in(1'b0, 4'd0, 1'b0);
        step();
        step();
        check("sweep_count", obs_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < obs_log.size(); i++) begin
            check("sweep_word", {16'b0, obs_log[i]}, 32'h1 << i);
        end
        check("sweep_first", {16'b0, obs_log.size() > 0 ? obs_log[0] : 16'hx}, 32'h0001);
        check("sweep_last", {16'b0, obs_log.size() > 15 ? obs_log[15] : 16'hx}, 32'h8000);

        // Back-pressure: 3 then 7 with out_ready low
        out_ready = 1'b0;
        set_in(1'b1, 4'd3, 1'b1);
        step();
        set_in(1'b1, 4'd7, 1'b1);
        step();
        set_in(1'b0, 4'd0, 1'b0);
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold", {16'b0, decoder_out}, 32'h0008);
        step();
        check("bp_hold2", {16'b0, decoder_out}, 32'h0008);
        out_ready = 1'b1;
        step();
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);
        check("bp_second", {16'b0, decoder_out}, 32'h0080);
        step();
        check("bp_drain", {31'b0, out_valid}, 32'd0);

        // Push and pop together at count 1
        obs_log.delete();
        out_ready = 1'b0;
        set_in(1'b1, 4'd1, 1'b1);
        step();
        out_ready = 1'b1;
        set_in(1'b1, 4'd2, 1'b1);
        step();
        out_ready = 1'b0;
        set_in(1'b1, 4'd4, 1'b1);
        step();
        out_ready = 1'b1;
        set_in(1'b0, 4'd0, 1'b0);
        step();
        step();
        step();
        check("sim_count", obs_log.size(), 32'd3);
        check("sim_0", {16'b0, obs_log.size() > 0 ? obs_log[0] : 16'hx}, 32'h0002);
        check("sim_1", {16'b0, obs_log.size() > 1 ? obs_log[1] : 16'hx}, 32'h0004);
        check("sim_2", {16'b0, obs_log.size() > 2 ? obs_log[2] : 16'hx}, 32'h0010);

        // Reset with two entries buffered and a push presented during reset
        out_ready = 1'b0;
        set_in(1'b1, 4'd10, 1'b1);
        step();
        set_in(1'b1, 4'd11, 1'b1);
        step();
        check("mid_full", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        set_in(1'b1, 4'd12, 1'b1);
        #1;
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        step();
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_word", {16'b0, decoder_out}, 32'h0);
        reset = 1'b0;
        set_in(1'b0, 4'd0, 1'b0);
        #1;
        check("mid_ready_back", {31'b0, in_ready}, 32'd1);
        obs_log.delete();
        out_ready = 1'b1;
        step();
        step();
        step();
        check("mid_no_stale", obs_log.size(), 32'd0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
